// File: rtl/coin_pkg.sv
// ----------------------------------------------------------------------------
// coin_pkg
// Definitions shared by the coin-credit path (acceptor and change dispenser).
//   COIN_UNIT_CENTS : value of one credit unit / one hopper coin, in cents
//   COIN_CREDIT_W   : default width of a credit value, in coin units
//   credit_t        : credit value type shared with the coin acceptor
//   disp_state_e    : change-dispenser FSM states
// ----------------------------------------------------------------------------
package coin_pkg;

  localparam int COIN_UNIT_CENTS = 50;
  localparam int COIN_CREDIT_W   = 2;

  typedef logic [COIN_CREDIT_W-1:0] credit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEND,
    ST_PAY,
    ST_GAP,
    ST_DONE
  } disp_state_e;

endpackage

// File: rtl/hopper_timeout_ctr.sv
// ----------------------------------------------------------------------------
// hopper_timeout_ctr
// Watchdog for a single hopper coin request. Cleared by load_i, counts every
// cycle en_i is high and flags expire_o during the LIMIT-th enabled cycle
// after the load.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high
//   load_i   : clear the count (entry into the wait state)
//   en_i     : count this cycle (waiting for the hopper)
//   expire_o : LIMIT enabled cycles have elapsed without a new load
// ----------------------------------------------------------------------------
module hopper_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // The count saturates at its terminal value so a wait that is never
  // released cannot wrap around and hide the expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // The first enabled cycle sees a count of 0, so LIMIT-1 marks the last one.
  assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/coin_change_dispenser.sv
// ----------------------------------------------------------------------------
// coin_change_dispenser
// Return side of the coin-credit path. Takes the credit accumulated by the
// coin acceptor, releases the product on a purchase, pays change to the
// hopper one coin per handshake, refunds everything on cancel and finally
// tells the acceptor to clear its credit.
// Build option:
//   HOPPER_TIMEOUT_EN : when defined, a coin request that is not acked within
//                       TIMEOUT_CYCLES cycles aborts payment with an err_o
//                       pulse; the unpaid coins remain visible on owed_o.
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high
//   credit_i       : credit from the acceptor (coin units), sampled in IDLE
//   buy_i          : purchase request (level), sampled in IDLE
//   cancel_i       : refund request (level), sampled in IDLE, beats buy_i
//   coin_ack_i     : hopper ejected one coin
//   vend_o         : one-cycle product release pulse
//   coin_o         : eject-coin request, held until acked
//   clear_credit_o : one-cycle pulse telling the acceptor to zero its credit
//   busy_o         : high whenever a transaction is in progress
//   err_o          : one-cycle pulse on insufficient credit (or timeout)
//   owed_o         : coins still to be paid in the current transaction
// ----------------------------------------------------------------------------
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int CREDIT_W       = COIN_CREDIT_W,
  parameter int PRICE          = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CREDIT_W-1:0] credit_i,
  input  logic                buy_i,
  input  logic                cancel_i,
  input  logic                coin_ack_i,
  output logic                vend_o,
  output logic                coin_o,
  output logic                clear_credit_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [CREDIT_W-1:0] owed_o
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  disp_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] owed_q, owed_d;
  logic                err_q, err_d;
  logic                timeout_hit;

`ifdef HOPPER_TIMEOUT_EN
  logic timeout_load;
  logic timeout_en;

  // Every coin gets its own full timeout window: the counter restarts
  // whenever PAY is entered, from VEND, GAP or IDLE alike.
  assign timeout_load = (state_q != ST_PAY) && (state_d == ST_PAY);
  assign timeout_en   = (state_q == ST_PAY);

  hopper_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load_i  (timeout_load),
    .en_i    (timeout_en),
    .expire_o(timeout_hit)
  );
`else
  // Without the watchdog the hopper is trusted to answer eventually.
  assign timeout_hit = 1'b0;
`endif

  // State, owed count and the registered error flag. Reset is asynchronous
  // so coin_o, which is decoded from the state, drops the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owed_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owed_q  <= owed_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a buy or
  // cancel during a transaction is dropped rather than queued. The owed
  // count only moves on entry from IDLE and on an ack in PAY, where it is
  // known to be non-zero, so it can never underflow.
  always_comb begin
    state_d = state_q;
    owed_d  = owed_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cancel_i) begin
          if (credit_i != '0) begin
            owed_d  = credit_i;
            state_d = ST_PAY;
          end
        end else if (buy_i) begin
          if (credit_i >= PRICE_C) begin
            owed_d  = credit_i - PRICE_C;
            state_d = ST_VEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_VEND: begin
        state_d = (owed_q != '0) ? ST_PAY : ST_DONE;
      end

      ST_PAY: begin
        if (coin_ack_i) begin
          owed_d  = owed_q - CREDIT_W'(1);
          state_d = ST_GAP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_GAP: begin
        state_d = (owed_q != '0) ? ST_PAY : ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign vend_o         = (state_q == ST_VEND);
  assign coin_o         = (state_q == ST_PAY);
  assign clear_credit_o = (state_q == ST_DONE);
  assign busy_o         = (state_q != ST_IDLE);
  assign err_o          = err_q;
  assign owed_o         = owed_q;

endmodule
